// File: rtl/merge2cam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : merge2cam_pkg
// Brief    : Shared encodings for the two-camera merge scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package merge2cam_pkg;

    localparam logic [1:0] MODE_BOTH = 2'b00;
    localparam logic [1:0] MODE_LEFT = 2'b01;
    localparam logic [1:0] MODE_RGHT = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WAIT_R = 2'b01;
    localparam logic [1:0] ST_WAIT_L = 2'b10;

    // 4 ms at 25 MHz
    localparam int C_DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage
`default_nettype wire

// File: rtl/merge2cam_sync_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at MAX_VAL; clear wins over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/merge2cam_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : merge2cam_sync_ctrl
// Brief    : Pairs left/right frame pulses within a timeout window and issues
//            merge strobes, degrading to single-camera mode on a stall.
// Revision : 1.0 - initial release
// ============================================================================
module merge2cam_sync_ctrl
    import merge2cam_pkg::*;
#(
    parameter int C_TIMEOUT_CYCLES  = C_DEFAULT_TIMEOUT_CYCLES,
    parameter int C_NB_TIMEOUT      = $clog2(C_TIMEOUT_CYCLES + 1),
    parameter int C_NB_MISS         = 8,
    parameter int C_MAX_CONSEC_MISS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clr_stats,
    input  logic                    new_frame_proc_l,
    input  logic                    new_frame_proc_r,
    output logic                    merge_strobe_o,
    output logic [1:0]              merge_mode_o,
    output logic [C_NB_TIMEOUT-1:0] skew_o,
    output logic [C_NB_MISS-1:0]    miss_cnt_l_o,
    output logic [C_NB_MISS-1:0]    miss_cnt_r_o,
    output logic                    cam_fail_l_o,
    output logic                    cam_fail_r_o,
    output logic                    busy_o
);

    localparam int                       C_NB_CONSEC  = $clog2(C_MAX_CONSEC_MISS + 1);
    localparam logic [C_NB_TIMEOUT-1:0]  C_CNT_LAST   = C_NB_TIMEOUT'(C_TIMEOUT_CYCLES - 1);
    localparam logic [C_NB_CONSEC-1:0]   C_CONSEC_MAX = C_NB_CONSEC'(C_MAX_CONSEC_MISS);
    localparam logic [C_NB_CONSEC-1:0]   C_CONSEC_ARM = C_NB_CONSEC'(C_MAX_CONSEC_MISS - 1);

    logic [1:0]              r_state;
    logic [C_NB_TIMEOUT-1:0] r_cnt;
    logic                    r_strobe;
    logic [1:0]              r_mode;
    logic [C_NB_TIMEOUT-1:0] r_skew;
    logic                    r_fail_l;
    logic                    r_fail_r;

    logic [1:0]              w_state_nxt;
    logic [C_NB_TIMEOUT-1:0] w_cnt_nxt;
    logic                    w_strobe_nxt;
    logic [1:0]              w_mode_nxt;
    logic [C_NB_TIMEOUT-1:0] w_skew_nxt;
    logic                    w_miss_l;
    logic                    w_miss_r;
    logic                    w_pair;
    logic [C_NB_CONSEC-1:0]  w_consec_l;
    logic [C_NB_CONSEC-1:0]  w_consec_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_mode   <= MODE_BOTH;
            r_skew   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_strobe <= w_strobe_nxt;
            r_mode   <= w_mode_nxt;
            r_skew   <= w_skew_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_strobe_nxt = 1'b0;
        w_mode_nxt   = r_mode;
        w_skew_nxt   = r_skew;
        w_miss_l     = 1'b0;
        w_miss_r     = 1'b0;
        w_pair       = 1'b0;

        if (!enable) begin
            // open window is dropped silently, nothing counted
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (new_frame_proc_l && new_frame_proc_r) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_BOTH;
                        w_skew_nxt   = '0;
                        w_pair       = 1'b1;
                    end else if (new_frame_proc_l) begin
                        if (r_fail_r) begin
                            w_strobe_nxt = 1'b1;
                            w_mode_nxt   = MODE_LEFT;
                        end else begin
                            w_state_nxt = ST_WAIT_R;
                        end
                    end else if (new_frame_proc_r) begin
                        if (r_fail_l) begin
                            w_strobe_nxt = 1'b1;
                            w_mode_nxt   = MODE_RGHT;
                        end else begin
                            w_state_nxt = ST_WAIT_L;
                        end
                    end
                end

                ST_WAIT_R: begin
                    if (new_frame_proc_r) begin
                        // a simultaneous left pulse reopens the window
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_BOTH;
                        w_skew_nxt   = r_cnt + C_NB_TIMEOUT'(1);
                        w_pair       = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = new_frame_proc_l ? ST_WAIT_R : ST_IDLE;
                    end else if (new_frame_proc_l) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_LEFT;
                        w_miss_r     = 1'b1;
                        w_cnt_nxt    = '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_LEFT;
                        w_miss_r     = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + C_NB_TIMEOUT'(1);
                    end
                end

                ST_WAIT_L: begin
                    if (new_frame_proc_l) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_BOTH;
                        w_skew_nxt   = r_cnt + C_NB_TIMEOUT'(1);
                        w_pair       = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = new_frame_proc_r ? ST_WAIT_L : ST_IDLE;
                    end else if (new_frame_proc_r) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_RGHT;
                        w_miss_l     = 1'b1;
                        w_cnt_nxt    = '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_strobe_nxt = 1'b1;
                        w_mode_nxt   = MODE_RGHT;
                        w_miss_l     = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + C_NB_TIMEOUT'(1);
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(C_NB_MISS)) u_miss_l (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_l),
        .i_clr   (clr_stats),
        .o_count (miss_cnt_l_o)
    );

    sat_counter #(.WIDTH(C_NB_MISS)) u_miss_r (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_r),
        .i_clr   (clr_stats),
        .o_count (miss_cnt_r_o)
    );

    // any completed pair ends both cameras' miss streaks
    sat_counter #(.WIDTH(C_NB_CONSEC), .MAX_VAL(C_CONSEC_MAX)) u_consec_l (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_l),
        .i_clr   (clr_stats | w_pair),
        .o_count (w_consec_l)
    );

    sat_counter #(.WIDTH(C_NB_CONSEC), .MAX_VAL(C_CONSEC_MAX)) u_consec_r (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_r),
        .i_clr   (clr_stats | w_pair),
        .o_count (w_consec_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fail_l <= 1'b0;
            r_fail_r <= 1'b0;
        end else begin
            if (clr_stats || w_pair) begin
                r_fail_l <= 1'b0;
            end else if (w_miss_l && (w_consec_l >= C_CONSEC_ARM)) begin
                r_fail_l <= 1'b1;
            end
            if (clr_stats || w_pair) begin
                r_fail_r <= 1'b0;
            end else if (w_miss_r && (w_consec_r >= C_CONSEC_ARM)) begin
                r_fail_r <= 1'b1;
            end
        end
    end

    assign merge_strobe_o = r_strobe;
    assign merge_mode_o   = r_mode;
    assign skew_o         = r_skew;
    assign cam_fail_l_o   = r_fail_l;
    assign cam_fail_r_o   = r_fail_r;
    assign busy_o         = (r_state == ST_WAIT_R) || (r_state == ST_WAIT_L);

endmodule
`default_nettype wire

// File: tb/tb_merge2cam_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge2cam_sync_ctrl
// Brief    : Directed + random bench for merge2cam_sync_ctrl against a
//            timestamp-based pairing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_merge2cam_sync_ctrl;

    localparam int T    = 16;
    localparam int MAXC = 4;
    localparam int SAT  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       clr_stats = 1'b0;
    logic       new_frame_proc_l = 1'b0;
    logic       new_frame_proc_r = 1'b0;
    logic       merge_strobe_o;
    logic [1:0] merge_mode_o;
    logic [4:0] skew_o;
    logic [7:0] miss_cnt_l_o;
    logic [7:0] miss_cnt_r_o;
    logic       cam_fail_l_o;
    logic       cam_fail_r_o;
    logic       busy_o;

    merge2cam_sync_ctrl #(
        .C_TIMEOUT_CYCLES  (T),
        .C_NB_TIMEOUT      (5),
        .C_NB_MISS         (8),
        .C_MAX_CONSEC_MISS (MAXC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .clr_stats        (clr_stats),
        .new_frame_proc_l (new_frame_proc_l),
        .new_frame_proc_r (new_frame_proc_r),
        .merge_strobe_o   (merge_strobe_o),
        .merge_mode_o     (merge_mode_o),
        .skew_o           (skew_o),
        .miss_cnt_l_o     (miss_cnt_l_o),
        .miss_cnt_r_o     (miss_cnt_r_o),
        .cam_fail_l_o     (cam_fail_l_o),
        .cam_fail_r_o     (cam_fail_r_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: an open window is remembered by which side opened it
    // and the cycle number of the opening pulse.
    int now = 0;
    int m_side = 0;       // 0 none, 1 left waiting for right, 2 right waiting for left
    int m_open_t = 0;
    int m_miss_l = 0, m_miss_r = 0, m_consec_l = 0, m_consec_r = 0;
    int m_strobe = 0, m_mode = 0, m_skew = 0;

    task automatic model_reset();
        m_side = 0; m_open_t = 0;
        m_miss_l = 0; m_miss_r = 0; m_consec_l = 0; m_consec_r = 0;
        m_strobe = 0; m_mode = 0; m_skew = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit en, input bit clr);
        bit pair, ml, mr, fl, fr;
        int age;
        pair = 0; ml = 0; mr = 0;
        fl = (m_consec_l == MAXC);
        fr = (m_consec_r == MAXC);
        now++;
        m_strobe = 0;
        if (!en) begin
            m_side = 0;
        end else if (m_side == 0) begin
            if (l && r) begin
                m_strobe = 1; m_mode = 0; m_skew = 0; pair = 1;
            end else if (l) begin
                if (fr) begin m_strobe = 1; m_mode = 1; end
                else begin m_side = 1; m_open_t = now; end
            end else if (r) begin
                if (fl) begin m_strobe = 1; m_mode = 2; end
                else begin m_side = 2; m_open_t = now; end
            end
        end else begin
            age = now - m_open_t;
            if ((m_side == 1 && r) || (m_side == 2 && l)) begin
                m_strobe = 1; m_mode = 0; m_skew = age; pair = 1;
                if (l && r) m_open_t = now;
                else m_side = 0;
            end else if ((m_side == 1 && l) || (m_side == 2 && r)) begin
                m_strobe = 1; m_mode = m_side;
                if (m_side == 1) mr = 1; else ml = 1;
                m_open_t = now;
            end else if (age == T) begin
                m_strobe = 1; m_mode = m_side;
                if (m_side == 1) mr = 1; else ml = 1;
                m_side = 0;
            end
        end
        if (clr) begin
            m_miss_l = 0; m_miss_r = 0; m_consec_l = 0; m_consec_r = 0;
        end else begin
            if (ml) begin
                m_miss_l   = (m_miss_l < SAT) ? m_miss_l + 1 : SAT;
                m_consec_l = (m_consec_l < MAXC) ? m_consec_l + 1 : MAXC;
            end
            if (mr) begin
                m_miss_r   = (m_miss_r < SAT) ? m_miss_r + 1 : SAT;
                m_consec_r = (m_consec_r < MAXC) ? m_consec_r + 1 : MAXC;
            end
            if (pair) begin m_consec_l = 0; m_consec_r = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        n_assert++;
        assert (obs === 32'(expv)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, now);
        end
    endtask

    task automatic check_all();
        chk("strobe", 32'(merge_strobe_o), m_strobe);
        chk("mode",   32'(merge_mode_o),   m_mode);
        chk("skew",   32'(skew_o),         m_skew);
        chk("miss_l", 32'(miss_cnt_l_o),   m_miss_l);
        chk("miss_r", 32'(miss_cnt_r_o),   m_miss_r);
        chk("fail_l", 32'(cam_fail_l_o),   (m_consec_l == MAXC) ? 1 : 0);
        chk("fail_r", 32'(cam_fail_r_o),   (m_consec_r == MAXC) ? 1 : 0);
        chk("busy",   32'(busy_o),         (m_side != 0) ? 1 : 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobe"}, 32'(merge_strobe_o), 0);
        chk({tag, "_mode"},   32'(merge_mode_o),   0);
        chk({tag, "_skew"},   32'(skew_o),         0);
        chk({tag, "_miss_l"}, 32'(miss_cnt_l_o),   0);
        chk({tag, "_miss_r"}, 32'(miss_cnt_r_o),   0);
        chk({tag, "_fail_l"}, 32'(cam_fail_l_o),   0);
        chk({tag, "_fail_r"}, 32'(cam_fail_r_o),   0);
        chk({tag, "_busy"},   32'(busy_o),         0);
    endtask

    // Inputs are applied 1 time unit after an edge and outputs sampled 1 after the next.
    task automatic tick(input bit l, input bit r);
        new_frame_proc_l = l;
        new_frame_proc_r = r;
        @(posedge clk);
        model_step(l, r, enable, clr_stats);
        #1;
        check_all();
        new_frame_proc_l = 1'b0;
        new_frame_proc_r = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    initial begin
        int phase;
        bit rl, rr;

        // reset state
        #12;
        check_zero("reset");
        rst = 1'b1;
        enable = 1'b1;
        model_reset();

        // simultaneous pair from IDLE
        tick(1, 1);
        chk("pair0_strobe", 32'(merge_strobe_o), 1);
        chk("pair0_mode", 32'(merge_mode_o), 0);
        tick(0, 0);
        chk("pair0_one_cycle", 32'(merge_strobe_o), 0);

        // L then R ten cycles later
        tick(1, 0);
        idle(9);
        tick(0, 1);
        chk("skew10", 32'(skew_o), 10);
        idle(2);

        // single timeout, then three more to raise the right fail flag
        for (int k = 0; k < 4; k++) begin
            tick(1, 0);
            idle(T);
            chk("timeout_mode", 32'(merge_mode_o), 1);
            if (k == 0) chk("timeout_miss_r", 32'(miss_cnt_r_o), 1);
        end
        chk("fail_r_set", 32'(cam_fail_r_o), 1);
        tick(1, 0);
        chk("failed_immediate_strobe", 32'(merge_strobe_o), 1);
        chk("failed_no_window", 32'(busy_o), 0);
        tick(1, 1);
        chk("fail_r_cleared", 32'(cam_fail_r_o), 0);

        // L+R inside WAIT_R reopens the window
        clr_stats = 1'b1;
        tick(0, 0);
        tick(1, 0);
        idle(3);
        tick(1, 1);
        chk("reopen_busy", 32'(busy_o), 1);
        idle(T);
        chk("reopen_timeout_mode", 32'(merge_mode_o), 1);
        chk("reopen_miss_r", 32'(miss_cnt_r_o), 1);

        // async reset in WAIT_L
        tick(0, 1);
        idle(3);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        rst = 1'b1;

        // enable dropped mid-window
        tick(1, 0);
        idle(4);
        enable = 1'b0;
        tick(0, 0);
        enable = 1'b1;
        idle(T + 4);
        chk("disable_no_miss", 32'(miss_cnt_r_o), 0);

        // miss counter saturation via repeated left pulses
        for (int i = 0; i < 257; i++) tick(1, 0);
        chk("miss_sat", 32'(miss_cnt_r_o), SAT);
        tick(1, 0);
        chk("miss_sat_hold", 32'(miss_cnt_r_o), SAT);
        tick(0, 1);
        clr_stats = 1'b1;
        tick(0, 0);

        // random traffic with occasional stalled cameras
        phase = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) phase = $urandom_range(0, 3);
            rl = ($urandom_range(0, 7) == 0) && (phase != 1);
            rr = ($urandom_range(0, 7) == 0) && (phase != 2);
            enable    = ($urandom_range(0, 59) != 0);
            clr_stats = ($urandom_range(0, 299) == 0);
            tick(rl, rr);
        end
        enable = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
